float2int_decoder: RTL and testbench

- Streaming decoder from the 7-bit compressed float code back to an 11-bit unsigned integer. It is the inverse of the team's int2float compressor.
- Sits on the decompression side of the datapath, between a code buffer and integer consumers.
- Uses a multi-cycle iterative left-shifter with valid/ready handshakes on both sides.
- One conversion is in flight at a time; back-to-back acceptance is supported from the HOLD state.

---
 rtl/float2int_decoder.sv | 106 ++++++++++
 tb/tb_float2int_decoder.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/float2int_decoder.sv
// float2int_decoder: iterative shift decoder from 7-bit float code to integer.
// Define FLOAT2INT_CONST_LAT_EN to pad every conversion to 2^EXP_W-1 cycles.
module float2int_decoder #(
  parameter int EXP_W = 3,
  parameter int MAN_W = 4,
  parameter int OUT_W = 11
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W-1:0] in_code,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [OUT_W-1:0]       out_int,
  output logic                   busy
);

  if (OUT_W != MAN_W + (1 << EXP_W) - 1) begin : g_bad_width
    $error("OUT_W must equal MAN_W + 2**EXP_W - 1");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_HOLD
  } state_t;

  state_t             r_state;
  logic [OUT_W-1:0]   r_acc;
  logic [EXP_W-1:0]   r_cnt;

  logic [EXP_W-1:0]   w_exp;
  logic [MAN_W-1:0]   w_man;
  logic               w_nz;
  logic [EXP_W-1:0]   w_n;
  logic [EXP_W-1:0]   w_cnt0;
  logic [OUT_W-1:0]   w_load;
  logic               w_take;
  logic               w_shen;

  assign w_exp  = in_code[EXP_W+MAN_W-1:MAN_W];
  assign w_man  = in_code[MAN_W-1:0];
  assign w_nz   = |w_exp;
  assign w_n    = w_nz ? w_exp - 1'b1 : '0;
  assign w_load = {{(OUT_W-MAN_W-1){1'b0}}, w_nz, w_man};

  assign out_valid = (r_state == S_HOLD);
  assign busy      = (r_state != S_IDLE);
  assign out_int   = r_acc;
  assign in_ready  = (r_state == S_IDLE)
                   | ((r_state == S_HOLD) & out_ready);
  assign w_take    = in_valid & in_ready;

`ifdef FLOAT2INT_CONST_LAT_EN
  // r_shf holds the real shifts left; r_cnt paces the fixed window.
  logic [EXP_W-1:0] r_shf;

  assign w_cnt0 = EXP_W'((1 << EXP_W) - 2);
  assign w_shen = (r_shf != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shf <= '0;
    end else if (w_take) begin
      r_shf <= w_n;
    end else if (r_state == S_SHIFT && w_shen) begin
      r_shf <= r_shf - 1'b1;
    end
  end
`else
  assign w_cnt0 = w_n;
  assign w_shen = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_acc   <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_HOLD: begin
          if (w_take) begin
            r_acc   <= w_load;
            r_cnt   <= w_cnt0;
            r_state <= (w_cnt0 != '0) ? S_SHIFT : S_HOLD;
          end else if (out_valid && out_ready) begin
            r_state <= S_IDLE;
          end
        end
        S_SHIFT: begin
          if (w_shen) begin
            r_acc <= r_acc << 1;
          end
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == EXP_W'(1)) begin
            r_state <= S_HOLD;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_float2int_decoder.sv
// tb_float2int_decoder: random + directed bench with a transaction-level model.
// Honours FLOAT2INT_CONST_LAT_EN for the expected latency.
module tb_float2int_decoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [6:0]  in_code = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [10:0] out_int;
  logic        busy;

  float2int_decoder dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_code  (in_code),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_int  (out_int),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp,
               $time);
    end
  endtask

  function automatic logic [10:0] dec(input logic [6:0] c);
    int e, m;
    e = int'(c[6:4]);
    m = int'(c[3:0]);
    if (e == 0) return 11'(m);
    return 11'((16 + m) << (e - 1));
  endfunction

  function automatic int lat(input logic [6:0] c);
`ifdef FLOAT2INT_CONST_LAT_EN
    return 6;
`else
    return (c[6:4] == 3'd0) ? 0 : int'(c[6:4]) - 1;
`endif
  endfunction

  // Model: one conversion in flight, result due after m_left more edges.
  bit          m_pend = 0;
  int          m_left = 0;
  logic [10:0] m_val  = '0;
  bit          m_zero = 1;
  logic [10:0] exp_q[$];
  logic [10:0] got_q[$];
  bit          f_in = 0, f_out = 0;
  logic [6:0]  c_in = '0;

  always @(negedge rst_n) begin
    m_pend = 0; m_left = 0; m_zero = 1;
    f_in = 0; f_out = 0;
    exp_q.delete();
  end

  always @(negedge clk) begin
    bit eo, ei;
    #2;
    if (rst_n) begin
      eo = m_pend && (m_left == 0);
      ei = !m_pend || (eo && out_ready);
      chk("out_valid", 32'(out_valid), 32'(eo));
      chk("in_ready", 32'(in_ready), 32'(ei));
      chk("busy", 32'(busy), 32'(m_pend));
      if (eo) chk("out_int", 32'(out_int), 32'(m_val));
      if (m_zero) chk("out_int_reset", 32'(out_int), 0);
      f_out = eo && out_ready;
      f_in  = ei && in_valid;
      c_in  = in_code;
      if (f_out) begin
        if (exp_q.size() == 0) begin
          chk("dup_result", 1, 0);
        end else begin
          chk("order", 32'(out_int), 32'(exp_q.pop_front()));
        end
        got_q.push_back(out_int);
      end
    end
  end

  always @(posedge clk) begin
    if (!rst_n) begin
      m_pend = 0; m_left = 0; m_zero = 1;
      f_in = 0; f_out = 0;
    end else begin
      if (f_out) m_pend = 0;
      else if (m_pend && m_left > 0) m_left--;
      if (f_in) begin
        m_pend = 1;
        m_val  = dec(c_in);
        m_left = lat(c_in);
        m_zero = 0;
        exp_q.push_back(m_val);
      end
      f_in = 0; f_out = 0;
    end
  end

  // 0: out_ready high, 1: low, 2: random
  int or_mode = 0;
  always @(negedge clk) begin
    if (or_mode == 2) out_ready = 1'($urandom_range(0, 1));
    else out_ready = (or_mode == 0);
  end

  task automatic send(input logic [6:0] c);
    int t = 0;
    in_valid = 1'b1;
    in_code  = c;
    #1;
    while (!in_ready && t < 200) begin
      @(negedge clk);
      #1;
      t++;
    end
    if (t >= 200) chk("send_timeout", 32'(t), 0);
    @(negedge clk);
    in_valid = 1'b0;
    in_code  = 7'($urandom);
  endtask

  task automatic wait_res(input int n);
    int t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (got_q.size() < n && t < 2000);
    chk("wait_res", 32'(got_q.size() >= n), 1);
  endtask

  task automatic meas_lat(input logic [6:0] c, input int exp_c,
                          input string nm);
    int c_cnt = 1;
    send(c);
    #1;
    while (!out_valid && c_cnt < 20) begin
      @(negedge clk);
      #1;
      c_cnt++;
    end
    chk(nm, 32'(c_cnt), 32'(exp_c));
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    @(negedge clk);
    #2;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_int", 32'(out_int), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    @(negedge clk);
    #3 rst_n = 1'b1;
    @(negedge clk);

    send(7'h00);
    send(7'h0F);
    send(7'h10);
    wait_res(3);
    chk("b2b_0x00", 32'(got_q[0]), 32'h000);
    chk("b2b_0x0F", 32'(got_q[1]), 32'h00F);
    chk("b2b_0x10", 32'(got_q[2]), 32'h010);

    meas_lat(7'h7F, 7, "lat_0x7F");
    wait_res(4);
    chk("max_0x7F", 32'(got_q[3]), 32'h7C0);
`ifdef FLOAT2INT_CONST_LAT_EN
    meas_lat(7'h00, 7, "lat_0x00");
`else
    meas_lat(7'h00, 1, "lat_0x00");
`endif
    wait_res(5);

    or_mode = 1;
    @(negedge clk);
    base = got_q.size();
    send(7'h35);
    in_valid = 1'b1;
    in_code  = 7'h12;
    repeat (8) @(negedge clk);
    #1;
    chk("hold_out_int", 32'(out_int), 32'h054);
    chk("hold_in_ready", 32'(in_ready), 0);
    @(negedge clk);
    or_mode = 0;
    send(7'h12);
    wait_res(base + 2);
    chk("hold_0x35", 32'(got_q[base]), 32'h054);
    chk("after_0x12", 32'(got_q[base + 1]), 32'h012);

    or_mode = 2;
    base = got_q.size();
    for (int i = 0; i < 128; i++) begin
      if ($urandom_range(0, 3) == 0) @(negedge clk);
      send(7'(i));
    end
    wait_res(base + 128);
    chk("sweep_count", 32'(got_q.size() - base), 128);

    or_mode = 0;
    @(negedge clk);
    @(negedge clk);
    base = got_q.size();
    send(7'h7F);
    @(negedge clk);
    @(negedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 32'(out_valid), 0);
    chk("arst_out_int", 32'(out_int), 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_in_ready", 32'(in_ready), 1);
    @(negedge clk);
    #3 rst_n = 1'b1;
    @(negedge clk);
    send(7'h21);
    wait_res(base + 1);
    chk("post_rst_0x21", 32'(got_q[base]), 32'h022);
    chk("no_drop_after_rst", 32'(got_q.size()), 32'(base + 1));

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 32'(exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
